// File: rtl/fixed_latency_pipe_scheduler_pkg.sv
// pipeSchedPkg: shared types and width helpers for the fixed-latency pipe scheduler.
package pipeSchedPkg;
  typedef enum logic [1:0] {RUN, DRAINING, DRAINED} sched_state_t;
  function automatic int tag_width(input int num_req);
    return $clog2(num_req);
  endfunction
  function automatic int credit_width(input int out_credits);
    return $clog2(out_credits + 1);
  endfunction
endpackage

// File: rtl/fixed_latency_pipe_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, priority starts just after last_grant.
module rr_arbiter
  import pipeSchedPkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int TAG_W = tag_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant
);
  logic [TAG_W-1:0] idx;
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = TAG_W'((32'(last_grant) + 32'(k)) % NUM_REQ);
      if (grant == '0 && req[idx]) grant[idx] = 1'b1;
    end
  end
endmodule

// File: rtl/fixed_latency_pipe_scheduler_shift_register.sv
// shift_register: plain register pipe of CYCLES stages without reset.
module shift_register #(
  parameter int WIDTH = 1,
  parameter int CYCLES = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [CYCLES];
  always_ff @(posedge clk) begin
    stage[0] <= d;
    for (int i = 1; i < CYCLES; i++) stage[i] <= stage[i-1];
  end
  assign q = stage[CYCLES-1];
endmodule

// File: rtl/fixed_latency_pipe_scheduler.sv
// fixed_latency_pipe_scheduler: credit-gated round-robin issue into a fixed-latency pipe with drain control.
// Optional PIPE_SCHED_STATS_EN enables the issue/stall statistics counters.
module fixed_latency_pipe_scheduler
  import pipeSchedPkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_LATENCY = 8,
  parameter int OUT_CREDITS = 16,
  localparam int TAG_W = tag_width(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic [NUM_REQ-1:0]              reqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   reqData,
  output logic [NUM_REQ-1:0]              reqReady,
  output logic                            pipeIssueValid,
  output logic [DATA_WIDTH-1:0]           pipeIssueData,
  input  logic [DATA_WIDTH-1:0]           pipeResultData,
  output logic                            outValid,
  output logic [TAG_W-1:0]                outTag,
  output logic [DATA_WIDTH-1:0]           outData,
  input  logic                            creditReturn,
  input  logic                            drainReq,
  output logic                            drainDone,
  output logic                            creditError,
  output logic [31:0]                     statIssued,
  output logic [31:0]                     statStalled
);
  localparam int CW = credit_width(OUT_CREDITS);
  localparam int IW = $clog2(PIPE_LATENCY + 2);
  sched_state_t state, state_nxt;
  logic [CW-1:0] credits;
  logic [IW-1:0] inflight, inflight_nxt;
  logic [TAG_W-1:0] last_grant, grant_idx, tag_dly;
  logic [NUM_REQ-1:0] grant;
  logic [PIPE_LATENCY-1:0] vld_pipe;
  logic hs, full;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(reqValid),
    .last_grant(last_grant),
    .grant(grant)
  );
  // last_grant holds the tag of the item on the issue stage whenever pipeIssueValid is high
  shift_register #(.WIDTH(TAG_W), .CYCLES(PIPE_LATENCY)) u_tag (
    .clk(clk),
    .d(last_grant),
    .q(tag_dly)
  );
  assign reqReady = (rstN && state == RUN && !drainReq && credits != '0) ? grant : '0;
  assign hs = |reqReady;
  assign full = credits == CW'(OUT_CREDITS);
  assign inflight_nxt = inflight + IW'(hs) - IW'(outValid);
  assign outValid = vld_pipe[PIPE_LATENCY-1];
  assign outTag = outValid ? tag_dly : '0;
  assign outData = pipeResultData;
  assign drainDone = state == DRAINED;
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant[i]) grant_idx = TAG_W'(i);
  end
  always_comb begin
    state_nxt = (state == RUN && drainReq) ? DRAINING :
                (state == DRAINING && inflight_nxt == '0) ? DRAINED :
                (state == DRAINED && !drainReq) ? RUN : state;
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= RUN;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      credits <= CW'(OUT_CREDITS);
      inflight <= '0;
      last_grant <= TAG_W'(NUM_REQ - 1);
      creditError <= 1'b0;
      pipeIssueValid <= 1'b0;
      pipeIssueData <= '0;
      vld_pipe <= '0;
    end else begin
      credits <= (hs && !creditReturn) ? credits - CW'(1) :
                 (creditReturn && !hs && !full) ? credits + CW'(1) : credits;
      creditError <= creditError | (creditReturn && !hs && full);
      inflight <= inflight_nxt;
      if (hs) last_grant <= grant_idx;
      pipeIssueValid <= hs;
      if (hs) pipeIssueData <= reqData[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
      vld_pipe <= PIPE_LATENCY'({vld_pipe, pipeIssueValid});
    end
  end
`ifdef PIPE_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      statIssued <= '0;
      statStalled <= '0;
    end else begin
      statIssued <= statIssued + 32'(hs);
      statStalled <= statStalled + 32'(|reqValid && !hs);
    end
  end
`else
  assign statIssued = '0;
  assign statStalled = '0;
`endif
endmodule

// File: tb/tb_fixed_latency_pipe_scheduler.sv
// tb_fixed_latency_pipe_scheduler: scoreboard bench with a cycle model of grants, credits and drain.
module tb_fixed_latency_pipe_scheduler;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int L = 8;
  localparam int OC = 16;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [NR-1:0] reqValid, reqReady;
  logic [NR*DW-1:0] reqData;
  logic pipeIssueValid, outValid, creditReturn, drainReq, drainDone, creditError;
  logic [DW-1:0] pipeIssueData, pipeResultData, outData;
  logic [1:0] outTag;
  logic [31:0] statIssued, statStalled;
  logic [DW-1:0] dl [L];
  typedef struct {int tag; logic [DW-1:0] data; int due;} exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0, cyc = 0, hs_obs = 0;
  int m_last, m_credits, m_state, m_inflight;
  logic m_err, m_prev_hs;
  logic [DW-1:0] m_prev_data;
  always #5 clk = ~clk;
  fixed_latency_pipe_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .PIPE_LATENCY(L), .OUT_CREDITS(OC)) dut (
    .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqData(reqData), .reqReady(reqReady),
    .pipeIssueValid(pipeIssueValid), .pipeIssueData(pipeIssueData), .pipeResultData(pipeResultData),
    .outValid(outValid), .outTag(outTag), .outData(outData), .creditReturn(creditReturn),
    .drainReq(drainReq), .drainDone(drainDone), .creditError(creditError),
    .statIssued(statIssued), .statStalled(statStalled)
  );
  // external datapath: exactly L cycles, inverts the payload
  always @(posedge clk) begin
    dl[0] <= pipeIssueData;
    for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
  end
  assign pipeResultData = ~dl[L-1];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [NR-1:0] model_grant();
    logic [NR-1:0] g = '0;
    if (rstN && m_state == 0 && !drainReq && m_credits != 0)
      for (int k = 1; k <= NR; k++) begin
        int idx = (m_last + k) % NR;
        if (g == '0 && reqValid[idx]) g[idx] = 1'b1;
      end
    return g;
  endfunction
  task automatic cycle();
    logic [NR-1:0] g;
    logic ev;
    int w, nxt;
    @(negedge clk);
    if (!rstN) begin
      m_last = NR - 1; m_credits = OC; m_state = 0; m_inflight = 0;
      m_err = 1'b0; m_prev_hs = 1'b0; sb.delete();
    end
    g = model_grant();
    ev = sb.size() > 0 && sb[0].due == cyc;
    check("req_ready", 32'(reqReady), 32'(g));
    check("out_valid", 32'(outValid), 32'(ev));
    check("out_tag", 32'(outTag), ev ? sb[0].tag : 0);
    if (ev) begin
      check("out_data", outData, sb[0].data);
      void'(sb.pop_front());
    end
    check("issue_valid", 32'(pipeIssueValid), 32'(m_prev_hs));
    if (m_prev_hs) check("issue_data", pipeIssueData, m_prev_data);
    check("drain_done", 32'(drainDone), 32'(m_state == 2));
    check("credit_error", 32'(creditError), 32'(m_err));
    if (|(reqValid & reqReady)) hs_obs++;
    if (rstN) begin
      w = 0;
      for (int k = 0; k < NR; k++) if (g[k]) w = k;
      nxt = m_inflight + int'(|g) - int'(ev);
      if (m_state == 0 && drainReq) m_state = 1;
      else if (m_state == 1 && nxt == 0) m_state = 2;
      else if (m_state == 2 && !drainReq) m_state = 0;
      if (|g && !creditReturn) m_credits--;
      else if (creditReturn && !(|g)) begin
        if (m_credits == OC) m_err = 1'b1;
        else m_credits++;
      end
      if (|g) begin
        sb.push_back(exp_t'{w, ~reqData[w*DW +: DW], cyc + 1 + L});
        m_last = w;
        m_prev_data = reqData[w*DW +: DW];
      end
      m_prev_hs = |g;
      m_inflight = nxt;
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) reqData[i*DW +: DW] = $urandom;
  endtask
  task automatic run(input int n);
    repeat (n) cycle();
  endtask
  initial begin
    int ov;
    reqValid = '0; reqData = '0; creditReturn = 1'b0; drainReq = 1'b0;
    #1;
    run(2);
    check("rst_issue_data", pipeIssueData, 32'd0);
    check("rst_out_tag", 32'(outTag), 32'd0);
    check("rst_stat_issued", statIssued, 32'd0);
    check("rst_stat_stalled", statStalled, 32'd0);
    rstN = 1'b1;
    reqValid = 4'b0101;
    run(8);
    reqValid = '0;
    run(L + 4);
    creditReturn = 1'b1;
    run(8);
    creditReturn = 1'b0;
    hs_obs = 0;
    reqValid = '1;
    run(20);
    check("grants_no_return", hs_obs, 16);
    check("ready_exhausted", 32'(reqReady), 32'd0);
    creditReturn = 1'b1;
    run(1);
    creditReturn = 1'b0;
    run(5);
    check("grant_after_return", hs_obs, 17);
    reqValid = '0;
    run(L + 3);
    creditReturn = 1'b1;
    run(1);
    reqValid = 4'b0001;
    hs_obs = 0;
    run(1);
    creditReturn = 1'b0;
    run(2);
    check("same_cycle_grants", hs_obs, 2);
    reqValid = '0;
    run(L + 3);
    creditReturn = 1'b1;
    run(16);
    creditReturn = 1'b0;
    reqValid = '1;
    run(8);
    drainReq = 1'b1;
    hs_obs = 0;
    for (int i = 0; i < 40 && !drainDone; i++) run(1);
    check("drain_reached", 32'(drainDone), 32'd1);
    check("drain_no_grants", hs_obs, 0);
    drainReq = 1'b0;
    run(2);
    check("resume_grant", hs_obs, 1);
    reqValid = '0;
    run(L + 3);
    reqValid = '1;
    run(5);
    rstN = 1'b0;
    reqValid = '0;
    run(2);
    rstN = 1'b1;
    ov = 0;
    repeat (L + 1) begin
      run(1);
      ov += int'(outValid);
    end
    check("reset_flush", ov, 0);
    creditReturn = 1'b1;
    run(1);
    creditReturn = 1'b0;
    run(3);
    check("credit_err_sticky", 32'(creditError), 32'd1);
    hs_obs = 0;
    reqValid = '1;
    run(24);
    check("credits_saturated", hs_obs, 16);
    reqValid = '0;
    run(L + 3);
    rstN = 1'b0;
    run(2);
    rstN = 1'b1;
    reqValid = '1;
    run(10);
    drainReq = 1'b1;
    run(4);
    reqValid = '0;
    for (int i = 0; i < 40 && !drainDone; i++) run(1);
    check("stats_drain_reached", 32'(drainDone), 32'd1);
    drainReq = 1'b0;
    run(2);
`ifdef PIPE_SCHED_STATS_EN
    check("stat_issued", statIssued, 32'd10);
    check("stat_stalled", statStalled, 32'd4);
`else
    check("stat_issued_off", statIssued, 32'd0);
    check("stat_stalled_off", statStalled, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
